// File: rtl/fir_engine_pkg.sv
// Shared types and default sizing for the FIR coefficient path.
package fir_engine_pkg;

    localparam int DefNTaps     = 13;
    localparam int DefDataWidth = 8;
    localparam int TapIdxWidth  = $clog2(DefNTaps);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2
    } load_state_e;

endpackage

// File: rtl/spi_coeff_loader_if.sv
// SPI pins from the host plus the coefficient write port towards the bank.
interface spi_coeff_loader_if import fir_engine_pkg::*; #(
    parameter int NTaps     = DefNTaps,
    parameter int DataWidth = DefDataWidth
) ();

    localparam int TapW = $clog2(NTaps);

    logic                 spiClk;
    logic                 mosi;
    logic                 cs;
    logic                 wrEn;
    logic [TapW-1:0]      wrAddr;
    logic [DataWidth-1:0] wrData;
    logic                 loadDone;
    logic                 busy;
    logic                 overrun;

    modport slave (
        input  spiClk, mosi, cs,
        output wrEn, wrAddr, wrData, loadDone, busy, overrun
    );

    modport master (
        output spiClk, mosi, cs,
        input  wrEn, wrAddr, wrData, loadDone, busy, overrun
    );

endinterface

// File: rtl/bit_sync.sv
// N-flop synchroniser for a single asynchronous bit, with selectable reset value.
module bit_sync #(
    parameter int   N      = 2,
    parameter logic RstVal = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [N-1:0] stages;

    // shift the raw input through the flop chain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stages <= {N{RstVal}};
        end else begin
            stages <= {stages[N-2:0], d};
        end
    end

    assign q = stages[N-1];

endmodule

// File: rtl/spi_coeff_loader.sv
// SPI slave that deserialises MSB-first coefficient words and writes them,
// one strobe per tap, into the FIR coefficient bank.
//
// state | meaning
// IDLE  | no frame open, waiting for cs to fall
// SHIFT | frame open, collecting bits and writing completed words
// FULL  | all taps written; further spiClk edges only flag overrun
module spi_coeff_loader import fir_engine_pkg::*; #(
    parameter int NTaps     = DefNTaps,
    parameter int DataWidth = DefDataWidth
) (
    input logic                clk,
    input logic                reset,
    spi_coeff_loader_if.slave  bus
);

    localparam int TapW = $clog2(NTaps);
    localparam int CntW = $clog2(DataWidth);
    localparam logic [TapW-1:0] LastTap = TapW'(NTaps - 1);
    localparam logic [CntW-1:0] LastBit = CntW'(DataWidth - 1);

    logic sclk_s, sclk_d, cs_s, cs_d, mosi_s;
    logic sclk_rise, cs_rise, cs_fall;

    load_state_e state, state_next;
    logic frame_start, shift_en, write_word, overrun_set;

    logic [CntW-1:0]      bit_cnt;
    logic [TapW-1:0]      tap_idx;
    logic [DataWidth-1:0] shreg;
    logic                 word_ready;

    logic                 wr_en, load_done, busy_q, overrun_q;
    logic [TapW-1:0]      wr_addr;
    logic [DataWidth-1:0] wr_data;

    bit_sync #(.N(2), .RstVal(1'b0)) u_sync_sclk (.clk(clk), .reset(reset), .d(bus.spiClk), .q(sclk_s));
    bit_sync #(.N(2), .RstVal(1'b1)) u_sync_cs   (.clk(clk), .reset(reset), .d(bus.cs),     .q(cs_s));
    bit_sync #(.N(2), .RstVal(1'b0)) u_sync_mosi (.clk(clk), .reset(reset), .d(bus.mosi),   .q(mosi_s));

    // delay flops for edge detection; mosi needs none since it is sampled with sclk_s
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_d <= 1'b0;
            cs_d   <= 1'b1;
        end else begin
            sclk_d <= sclk_s;
            cs_d   <= cs_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next state and datapath controls; a cs rise always takes priority over data
    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        shift_en    = 1'b0;
        write_word  = 1'b0;
        overrun_set = 1'b0;
        unique case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next  = SHIFT;
                    frame_start = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_next = IDLE;
                end else begin
                    shift_en = sclk_rise;
                    if (word_ready) begin
                        write_word = 1'b1;
                        if (tap_idx == LastTap) begin
                            state_next = FULL;
                        end
                    end
                end
            end
            FULL: begin
                if (cs_rise) begin
                    state_next = IDLE;
                end else begin
                    overrun_set = sclk_rise;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // shift register, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt    <= '0;
            tap_idx    <= '0;
            shreg      <= '0;
            word_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            load_done  <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            wr_en     <= write_word;
            load_done <= wr_en && (wr_addr == LastTap);
            busy_q    <= (state_next != IDLE);
            if (frame_start) begin
                bit_cnt    <= '0;
                tap_idx    <= '0;
                shreg      <= '0;
                word_ready <= 1'b0;
                overrun_q  <= 1'b0;
            end else begin
                word_ready <= 1'b0;
                if (shift_en) begin
                    shreg <= {shreg[DataWidth-2:0], mosi_s};
                    if (bit_cnt == LastBit) begin
                        bit_cnt    <= '0;
                        word_ready <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                if (write_word) begin
                    wr_addr <= tap_idx;
                    wr_data <= shreg;
                    // saturate so the index can never run past the last tap
                    if (tap_idx != LastTap) begin
                        tap_idx <= tap_idx + 1'b1;
                    end
                end
                if (overrun_set) begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    assign bus.wrEn     = wr_en;
    assign bus.wrAddr   = wr_addr;
    assign bus.wrData   = wr_data;
    assign bus.loadDone = load_done;
    assign bus.busy     = busy_q;
    assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_spi_coeff_loader.sv
// Directed-random bench for spi_coeff_loader with a frame-level reference model.
module tb_spi_coeff_loader;

    localparam int NT = 13;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset;
    int   tests, fails;
    int   cyc = 0;
    int   last_rise_cyc = 0;

    logic [7:0] tx_words[$];
    bit         txq[$];
    logic [3:0] got_addr[$];
    logic [7:0] got_data[$];
    int         got_lat[$];
    int         ld_cnt, ld_follow;
    bit         prev_wr_last = 1'b0;

    spi_coeff_loader_if bus ();

    spi_coeff_loader dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // observe writes and loadDone away from the active edge
    always @(negedge clk) begin
        if (bus.wrEn) begin
            got_addr.push_back(bus.wrAddr);
            got_data.push_back(bus.wrData);
            got_lat.push_back(cyc - last_rise_cyc);
        end
        if (bus.loadDone) begin
            ld_cnt++;
            if (prev_wr_last) ld_follow++;
        end
        prev_wr_last = bus.wrEn && (bus.wrAddr == 4'(NT - 1));
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build_bits(input int extra);
        txq.delete();
        foreach (tx_words[w])
            for (int b = DW - 1; b >= 0; b--) txq.push_back(tx_words[w][b]);
        for (int i = 0; i < extra; i++) txq.push_back(1'($urandom_range(0, 1)));
    endtask

    task automatic random_words(input int n);
        tx_words.delete();
        for (int i = 0; i < n; i++) tx_words.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic start_frame(input string name);
        got_addr.delete();
        got_data.delete();
        got_lat.delete();
        ld_cnt = 0;
        ld_follow = 0;
        @(negedge clk);
        bus.cs = 1'b0;
        repeat (2) @(negedge clk);
        check({name, "/busy_pre"}, 32'(bus.busy), 0);
        @(negedge clk);
        check({name, "/busy_rise"}, 32'(bus.busy), 1);
        @(negedge clk);
    endtask

    task automatic end_frame(input string name);
        @(negedge clk);
        bus.cs = 1'b1;
        repeat (2) @(negedge clk);
        check({name, "/busy_hold"}, 32'(bus.busy), 1);
        @(negedge clk);
        check({name, "/busy_fall"}, 32'(bus.busy), 0);
        repeat (3) @(negedge clk);
    endtask

    // mode 0: mosi set while spiClk low; late mode changes mosi 2 cycles after each rise
    task automatic shift_bits(input int hi, input int lo, input bit late);
        for (int i = 0; i < txq.size(); i++) begin
            if (!late || i == 0) bus.mosi = txq[i];
            repeat (lo) @(negedge clk);
            bus.spiClk = 1'b1;
            last_rise_cyc = cyc;
            if (late) begin
                repeat (2) @(negedge clk);
                if (i + 1 < txq.size()) bus.mosi = txq[i + 1];
                repeat (hi - 2) @(negedge clk);
            end else begin
                repeat (hi) @(negedge clk);
            end
            bus.spiClk = 1'b0;
        end
        repeat (8) @(negedge clk);
    endtask

    // frame-level expectations: whole words up to NT, loadDone iff NT words, overrun iff extra bits
    task automatic verify(input string name);
        int nb, exp_n, exp_ld, exp_ovr;
        nb      = txq.size();
        exp_n   = (nb / DW > NT) ? NT : nb / DW;
        exp_ld  = (nb >= NT * DW) ? 1 : 0;
        exp_ovr = (nb > NT * DW) ? 1 : 0;
        check({name, "/writes"}, 32'(got_addr.size()), 32'(exp_n));
        for (int i = 0; i < exp_n && i < got_addr.size(); i++) begin
            check($sformatf("%s/addr%0d", name, i), 32'(got_addr[i]), 32'(i));
            check($sformatf("%s/data%0d", name, i), 32'(got_data[i]), 32'(tx_words[i]));
            check($sformatf("%s/lat%0d", name, i), 32'(got_lat[i]), 4);
        end
        check({name, "/load_done"}, 32'(ld_cnt), 32'(exp_ld));
        check({name, "/load_done_follow"}, 32'(ld_follow), 32'(exp_ld));
        check({name, "/overrun"}, 32'(bus.overrun), 32'(exp_ovr));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "/wrEn"}, 32'(bus.wrEn), 0);
        check({name, "/wrAddr"}, 32'(bus.wrAddr), 0);
        check({name, "/wrData"}, 32'(bus.wrData), 0);
        check({name, "/loadDone"}, 32'(bus.loadDone), 0);
        check({name, "/busy"}, 32'(bus.busy), 0);
        check({name, "/overrun"}, 32'(bus.overrun), 0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        bus.cs = 1'b1;
        bus.spiClk = 1'b0;
        bus.mosi = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // full frame 0x01..0x0D at clk/8
        tx_words.delete();
        for (int i = 1; i <= NT; i++) tx_words.push_back(8'(i));
        build_bits(0);
        start_frame("full");
        shift_bits(4, 4, 1'b0);
        verify("full");
        end_frame("full");

        // MSB-first order and sign bits untouched
        tx_words.delete();
        tx_words.push_back(8'h80);
        tx_words.push_back(8'hFF);
        build_bits(0);
        start_frame("sign");
        shift_bits(4, 4, 1'b0);
        verify("sign");
        end_frame("sign");

        // short frame with a dangling partial word
        random_words(2);
        build_bits(5);
        start_frame("partial");
        shift_bits(4, 4, 1'b0);
        verify("partial");
        end_frame("partial");

        random_words(NT);
        build_bits(0);
        start_frame("restart");
        shift_bits(4, 4, 1'b0);
        verify("restart");
        end_frame("restart");

        // overrun: extra bits past the last tap
        random_words(NT);
        build_bits(3);
        start_frame("ovr");
        shift_bits(4, 4, 1'b0);
        verify("ovr");
        end_frame("ovr");
        check("ovr/sticky_after_cs", 32'(bus.overrun), 1);
        start_frame("ovr_next");
        check("ovr_next/cleared", 32'(bus.overrun), 0);
        end_frame("ovr_next");

        // reset in the middle of word 4
        random_words(3);
        build_bits(4);
        start_frame("rst_mid");
        shift_bits(4, 4, 1'b0);
        check("rst_mid/writes_before", 32'(got_addr.size()), 3);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_all_zero("rst_mid");
        bus.cs = 1'b1;
        bus.spiClk = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        random_words(NT);
        build_bits(0);
        start_frame("after_rst");
        shift_bits(4, 4, 1'b0);
        verify("after_rst");
        end_frame("after_rst");

        // minimum spiClk high/low with late mosi changes
        random_words(NT);
        build_bits(0);
        start_frame("min_timing");
        shift_bits(3, 3, 1'b1);
        verify("min_timing");
        end_frame("min_timing");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
